// File: rtl/cc_mim_pkg.sv
// Shared definitions for the ARC microprogram sequencer: widths,
// microword field positions, COND encodings and the sequencer state type.
package cc_mim_pkg;

    localparam int DATAWIDTH_MICROWORD = 41;
    localparam int DATAWIDTH_MICROADDR = 11;
    localparam int DATAWIDTH_IR        = 32;

    // Microword field positions, MSB first
    localparam int A_MSB     = 40;
    localparam int A_LSB     = 35;
    localparam int AMUX_BIT  = 34;
    localparam int B_MSB     = 33;
    localparam int B_LSB     = 28;
    localparam int BMUX_BIT  = 27;
    localparam int C_MSB     = 26;
    localparam int C_LSB     = 21;
    localparam int CMUX_BIT  = 20;
    localparam int RD_BIT    = 19;
    localparam int WR_BIT    = 18;
    localparam int ALU_MSB   = 17;
    localparam int ALU_LSB   = 14;
    localparam int COND_MSB  = 13;
    localparam int COND_LSB  = 11;
    localparam int JUMP_MSB  = 10;
    localparam int JUMP_LSB  = 0;

    // Next-address selection codes carried in the COND field
    localparam logic [2:0] COND_NEXT   = 3'b000;
    localparam logic [2:0] COND_N      = 3'b001;
    localparam logic [2:0] COND_Z      = 3'b010;
    localparam logic [2:0] COND_V      = 3'b011;
    localparam logic [2:0] COND_C      = 3'b100;
    localparam logic [2:0] COND_IR13   = 3'b101;
    localparam logic [2:0] COND_JUMP   = 3'b110;
    localparam logic [2:0] COND_DECODE = 3'b111;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'b00,
        ST_EXEC    = 2'b01,
        ST_MEMWAIT = 2'b10
    } seq_state_t;

    // Instruction dispatch address: opcode class and op3 field select a
    // four-word slot in the upper half of the control store.
    function automatic logic [DATAWIDTH_MICROADDR-1:0] decode_addr(
        input logic [DATAWIDTH_IR-1:0] ir
    );
        return {1'b1, ir[31:30], ir[24:19], 2'b00};
    endfunction

endpackage

// File: rtl/cc_mim_nextaddr.sv
// Combinational next-microaddress selection: increment, conditional or
// unconditional branch to JUMP, or instruction decode dispatch.
module cc_mim_nextaddr
    import cc_mim_pkg::*;
(
    input  logic [DATAWIDTH_MICROADDR-1:0] csar,
    input  logic [2:0]                     cond,
    input  logic [DATAWIDTH_MICROADDR-1:0] jump,
    input  logic [3:0]                     nzvc,
    input  logic [DATAWIDTH_IR-1:0]        ir,
    output logic [DATAWIDTH_MICROADDR-1:0] next_addr
);

    logic [DATAWIDTH_MICROADDR-1:0] csar_inc;

    // Address width is exactly the store depth, so the increment wraps 2047 -> 0
    assign csar_inc = csar + 11'd1;

    // Pick the branch target according to COND and the sampled flags/IR
    always_comb begin
        next_addr = csar_inc;
        case (cond)
            COND_NEXT:   next_addr = csar_inc;
            COND_N:      next_addr = nzvc[3] ? jump : csar_inc;
            COND_Z:      next_addr = nzvc[2] ? jump : csar_inc;
            COND_V:      next_addr = nzvc[1] ? jump : csar_inc;
            COND_C:      next_addr = nzvc[0] ? jump : csar_inc;
            COND_IR13:   next_addr = ir[13]  ? jump : csar_inc;
            COND_JUMP:   next_addr = jump;
            COND_DECODE: next_addr = decode_addr(ir);
            default:     next_addr = csar_inc;
        endcase
    end

endmodule

// File: rtl/cc_mim_microsequencer.sv
// ARC microprogram sequencer: drives CSAR to the control store, latches the
// returned microword into the MIR, stalls on memory accesses and issues one
// commit pulse per microinstruction.
module cc_mim_microsequencer
    import cc_mim_pkg::*;
(
    input  logic                           CLOCK_50,
    input  logic                           RESET_InHigh,
    input  logic                           run_InHigh,
    input  logic [DATAWIDTH_MICROWORD-1:0] cs_data_InBUS,
    input  logic [DATAWIDTH_IR-1:0]        ir_InBUS,
    input  logic [3:0]                     psr_nzvc_InBUS,
    input  logic                           mem_ack_InHigh,
    output logic [DATAWIDTH_MICROADDR-1:0] cs_addr_OutBUS,
    output logic [DATAWIDTH_MICROWORD-1:0] mir_OutBUS,
    output logic                           mem_rd_OutHigh,
    output logic                           mem_wr_OutHigh,
    output logic                           commit_OutHigh
);

    seq_state_t                     state_reg, state_next;
    logic [DATAWIDTH_MICROADDR-1:0] csar_reg, csar_next;
    logic [DATAWIDTH_MICROWORD-1:0] mir_reg, mir_next;
    logic [DATAWIDTH_MICROADDR-1:0] next_addr;
    logic                           commit;
    logic                           mem_active;
    logic                           mir_mem;

    // Flags and IR are taken live, so they are sampled in the commit cycle
    cc_mim_nextaddr u_nextaddr (
        .csar      (csar_reg),
        .cond      (mir_reg[COND_MSB:COND_LSB]),
        .jump      (mir_reg[JUMP_MSB:JUMP_LSB]),
        .nzvc      (psr_nzvc_InBUS),
        .ir        (ir_InBUS),
        .next_addr (next_addr)
    );

    assign mir_mem = mir_reg[RD_BIT] | mir_reg[WR_BIT];

    // Sequencer state, CSAR and MIR registers; reset abandons any pending access
    always_ff @(posedge CLOCK_50) begin
        if (RESET_InHigh) begin
            state_reg <= ST_FETCH;
            csar_reg  <= '0;
            mir_reg   <= '0;
        end else begin
            state_reg <= state_next;
            csar_reg  <= csar_next;
            mir_reg   <= mir_next;
        end
    end

    // Next-state, register updates and commit/strobe qualification
    always_comb begin
        state_next = state_reg;
        csar_next  = csar_reg;
        mir_next   = mir_reg;
        commit     = 1'b0;
        mem_active = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                // run is only looked at here, so a running instruction always completes
                if (run_InHigh) begin
                    mir_next   = cs_data_InBUS;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                mem_active = 1'b1;
                // An ack seen here is ignored; memory words always pass through MEMWAIT
                if (mir_mem) begin
                    state_next = ST_MEMWAIT;
                end else begin
                    commit     = 1'b1;
                    csar_next  = next_addr;
                    state_next = ST_FETCH;
                end
            end
            ST_MEMWAIT: begin
                mem_active = 1'b1;
                if (mem_ack_InHigh) begin
                    commit     = 1'b1;
                    csar_next  = next_addr;
                    state_next = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    assign cs_addr_OutBUS = csar_reg;
    assign mir_OutBUS     = mir_reg;
    assign mem_rd_OutHigh = mem_active & mir_reg[RD_BIT];
    assign mem_wr_OutHigh = mem_active & mir_reg[WR_BIT];
    assign commit_OutHigh = commit;

endmodule

// File: tb/tb_cc_mim_microsequencer.sv
// Directed bench for the ARC microsequencer with a small control store model.
module tb_cc_mim_microsequencer;

    logic        clk;
    logic        rst;
    logic        run;
    logic [40:0] cs_data;
    logic [31:0] ir;
    logic [3:0]  psr;
    logic        mem_ack;
    logic [10:0] cs_addr;
    logic [40:0] mir;
    logic        mem_rd;
    logic        mem_wr;
    logic        commit;

    int vectors = 0;
    int miscompares = 0;

    logic [40:0] rom [2048];

    assign cs_data = rom[cs_addr];

    cc_mim_microsequencer dut (
        .CLOCK_50       (clk),
        .RESET_InHigh   (rst),
        .run_InHigh     (run),
        .cs_data_InBUS  (cs_data),
        .ir_InBUS       (ir),
        .psr_nzvc_InBUS (psr),
        .mem_ack_InHigh (mem_ack),
        .cs_addr_OutBUS (cs_addr),
        .mir_OutBUS     (mir),
        .mem_rd_OutHigh (mem_rd),
        .mem_wr_OutHigh (mem_wr),
        .commit_OutHigh (commit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [40:0] mw(input logic [20:0] hi, input logic rd,
                                       input logic wr, input logic [2:0] cond,
                                       input logic [10:0] jump);
        return {hi, rd, wr, 4'hA, cond, jump};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one microinstruction starting in FETCH. ack_k<0 holds ack high
    // throughout; ack_k>0 raises ack in the k-th MEMWAIT cycle.
    task automatic exec_instr(input string tag, input int ack_k, input bit drop_run,
                              input logic [40:0] exp_mir, input logic [10:0] exp_next,
                              input int exp_cycles, input int exp_rd, input int exp_wr);
        int cycles = 0;
        int rd_cnt = 0;
        int wr_cnt = 0;
        int strobe_cnt = 0;
        int commits = 0;
        bit done = 0;
        while (!done && cycles < 20) begin
            cycles++;
            if (mem_rd) rd_cnt++;
            if (mem_wr) wr_cnt++;
            if (mem_rd || mem_wr) strobe_cnt++;
            mem_ack = (ack_k < 0) || (ack_k > 0 && strobe_cnt == ack_k + 1);
            if (drop_run && cycles == 2) run = 1'b0;
            #1;
            if (commit) begin
                commits++;
                done = 1;
            end
            tick();
        end
        mem_ack = 1'b0;
        chk({tag, "_cycles"}, cycles, exp_cycles);
        chk({tag, "_commits"}, commits, 1);
        chk({tag, "_rd_cycles"}, rd_cnt, exp_rd);
        chk({tag, "_wr_cycles"}, wr_cnt, exp_wr);
        chk({tag, "_csar"}, cs_addr, exp_next);
        chk({tag, "_mir"}, mir, exp_mir);
        chk({tag, "_commit_fetch"}, commit, 0);
        $display("instr %s: csar=%0d cycles=%0d rd=%0d wr=%0d", tag, cs_addr, cycles, rd_cnt, wr_cnt);
    endtask

    logic [40:0] w_dec, w_ir13, w_j1600, w_rd2047, w_next, w_z12, w_j2047, w_rw5, w_rdnext;
    logic [31:0] ir_dec1, ir_dec0;

    initial begin
        w_dec    = mw(21'h0F0F0, 1'b0, 1'b0, 3'b111, 11'd0);
        w_ir13   = mw(21'h12345, 1'b0, 1'b0, 3'b101, 11'd1602);
        w_j1600  = mw(21'h1FFFF, 1'b0, 1'b0, 3'b110, 11'd1600);
        w_rd2047 = mw(21'h0AAAA, 1'b1, 1'b0, 3'b110, 11'd2047);
        w_next   = mw(21'h15555, 1'b0, 1'b0, 3'b000, 11'd5);
        w_z12    = mw(21'h00001, 1'b0, 1'b0, 3'b010, 11'd12);
        w_j2047  = mw(21'h10000, 1'b0, 1'b0, 3'b110, 11'd2047);
        w_rw5    = mw(21'h0C3C3, 1'b1, 1'b1, 3'b110, 11'd5);
        w_rdnext = mw(21'h1E1E1, 1'b1, 1'b0, 3'b000, 11'd100);
        ir_dec1  = {2'b10, 5'b00000, 6'b010000, 5'b00000, 1'b1, 13'h0};
        ir_dec0  = {2'b10, 5'b00000, 6'b010000, 5'b00000, 1'b0, 13'h0};

        for (int i = 0; i < 2048; i++) rom[i] = '0;
        rom[1]    = w_dec;
        rom[1600] = w_ir13;
        rom[1602] = w_j1600;
        rom[1601] = w_rd2047;
        rom[2047] = w_next;
        rom[12]   = w_j2047;
        rom[5]    = w_rdnext;

        rst = 1'b1; run = 1'b0; ir = ir_dec1; psr = 4'b0000; mem_ack = 1'b0;
        tick(); tick();
        chk("reset_csar", cs_addr, 11'd0);
        chk("reset_mir", mir, 41'd0);
        chk("reset_rd", mem_rd, 0);
        chk("reset_wr", mem_wr, 0);
        chk("reset_commit", commit, 0);
        $display("reset: csar=%0d mir=%0h", cs_addr, mir);
        rst = 1'b0; run = 1'b1;

        exec_instr("word0_next", 0, 1'b0, 41'd0, 11'd1, 2, 0, 0);
        rom[0] = w_z12;
        exec_instr("decode", 0, 1'b0, w_dec, 11'd1600, 2, 0, 0);
        exec_instr("ir13_taken", 0, 1'b0, w_ir13, 11'd1602, 2, 0, 0);
        exec_instr("jump_droprun", 0, 1'b1, w_j1600, 11'd1600, 2, 0, 0);

        for (int i = 0; i < 3; i++) begin
            chk("hold_commit", commit, 0);
            chk("hold_rd", mem_rd, 0);
            tick();
        end
        chk("hold_csar", cs_addr, 11'd1600);
        chk("hold_mir", mir, w_j1600);
        $display("hold: csar=%0d", cs_addr);
        run = 1'b1;

        ir = ir_dec0;
        exec_instr("ir13_not_taken", 0, 1'b0, w_ir13, 11'd1601, 2, 0, 0);
        exec_instr("mem_stall_k3", 3, 1'b0, w_rd2047, 11'd2047, 5, 4, 0);
        exec_instr("wrap_next", 0, 1'b0, w_next, 11'd0, 2, 0, 0);
        rom[2047] = w_z12;
        psr = 4'b0100;
        exec_instr("z_taken", 0, 1'b0, w_z12, 11'd12, 2, 0, 0);
        rom[0] = w_rw5;
        exec_instr("jump_2047", 0, 1'b0, w_j2047, 11'd2047, 2, 0, 0);
        psr = 4'b1011;
        exec_instr("z_not_taken_wrap", 0, 1'b0, w_z12, 11'd0, 2, 0, 0);
        exec_instr("rdwr_ack_in_exec", -1, 1'b0, w_rw5, 11'd5, 3, 2, 2);

        // Reset while stalled in MEMWAIT at address 5
        tick();
        chk("rstmw_exec_rd", mem_rd, 1);
        tick();
        chk("rstmw_wait_rd", mem_rd, 1);
        rst = 1'b1;
        #1;
        chk("rstmw_commit_before", commit, 0);
        tick();
        chk("rstmw_csar", cs_addr, 11'd0);
        chk("rstmw_mir", mir, 41'd0);
        chk("rstmw_rd", mem_rd, 0);
        chk("rstmw_commit", commit, 0);
        $display("reset in memwait: csar=%0d mir=%0h rd=%0d", cs_addr, mir, mem_rd);
        rst = 1'b0;

        exec_instr("after_reset_rdwr_k1", 1, 1'b0, w_rw5, 11'd5, 3, 2, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
